// File: rtl/part_pkg.sv
// -----------------------------------------------------------------------------
// part_pkg
// Shared definitions for the partition (poker) test readout path.
//   NUM_BINS_DEFAULT : default number of 64-bit bin counters
//   HDR_MAGIC        : upper 16 bits of the frame header word
//   readout_state_t  : readout FSM states
//   frame_len(n)     : frame length in 32-bit words for n bins
// -----------------------------------------------------------------------------
package part_pkg;

    localparam int          NUM_BINS_DEFAULT = 32;
    localparam logic [15:0] HDR_MAGIC        = 16'hA5A5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } readout_state_t;

    // Header + total (2 words) + 2 words per bin + checksum.
    function automatic int frame_len(input int n);
        return 2 * n + 4;
    endfunction

endpackage

// File: rtl/part_readout.sv
// -----------------------------------------------------------------------------
// part_readout
// Snapshots the partition-test bin counters and sample total on a start pulse
// and streams them as a framed sequence of 32-bit words over valid/ready,
// finishing with an XOR checksum word.
//
// Ports:
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-low reset
//   start     : snapshot-and-send request (honoured in IDLE only)
//   counts    : live bin counters, NUM_BINS x 64 bits
//   total     : live 64-bit sample total
//   out_data  : frame word
//   out_valid : out_data is valid
//   out_last  : current word is the checksum word
//   out_ready : consumer accepts the word
//   busy      : high from snapshot until the final handshake
//   done      : one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module part_readout
    import part_pkg::*;
#(
    parameter int NUM_BINS = NUM_BINS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_BINS-1:0][63:0] counts,
    input  logic [63:0]              total,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int FRAME_LEN = frame_len(NUM_BINS);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [31:0]      HDR_WORD = {HDR_MAGIC, 16'(NUM_BINS)};

    readout_state_t            state_reg;
    logic [IDX_W-1:0]          idx_reg;
    logic [31:0]               cksum_reg;
    logic [NUM_BINS-1:0][63:0] snap_counts_reg;
    logic [63:0]               snap_total_reg;
    logic [31:0]               out_data_reg;
    logic                      out_valid_reg;
    logic                      out_last_reg;
    logic                      busy_reg;
    logic                      done_reg;

    logic [IDX_W-1:0]          idx_next;
    logic [31:0]               word_next;
    logic                      handshake;

    // Frame word table, indexed by word position. Everything except the
    // header and checksum comes from the snapshot, so live inputs never
    // reach the stream.
    logic [31:0] word_tab [FRAME_LEN];

    assign word_tab[0] = HDR_WORD;
    assign word_tab[1] = snap_total_reg[31:0];
    assign word_tab[2] = snap_total_reg[63:32];

    generate
        for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin_words
            assign word_tab[3 + 2*gi] = snap_counts_reg[gi][31:0];
            assign word_tab[4 + 2*gi] = snap_counts_reg[gi][63:32];
        end
    endgenerate

    // The checksum word is loaded on the handshake of word FRAME_LEN-2, so it
    // must already include the word being accepted in that cycle.
    assign word_tab[FRAME_LEN-1] = cksum_reg ^ out_data_reg;

    assign handshake = out_valid_reg & out_ready;
    assign idx_next  = idx_reg + 1'b1;

    always_comb begin
        word_next = word_tab[idx_next];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            cksum_reg       <= '0;
            snap_counts_reg <= '0;
            snap_total_reg  <= '0;
            out_data_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        snap_counts_reg <= counts;
                        snap_total_reg  <= total;
                        idx_reg         <= '0;
                        cksum_reg       <= '0;
                        out_data_reg    <= word_tab[0];
                        out_valid_reg   <= 1'b1;
                        out_last_reg    <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= SEND;
                    end
                end
                SEND: begin
                    // start is deliberately not looked at here.
                    if (handshake) begin
                        cksum_reg <= cksum_reg ^ out_data_reg;
                        if (idx_reg == LAST_IDX) begin
                            state_reg     <= IDLE;
                            out_data_reg  <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            idx_reg      <= idx_next;
                            out_data_reg <= word_next;
                            out_last_reg <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_part_readout.sv
module tb_part_readout;

    localparam int NB = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [NB-1:0][63:0] counts = '0;
    logic [63:0]         total = '0;
    logic [31:0]         out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_ready = 1'b0;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    part_readout #(.NUM_BINS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .counts    (counts),
        .total     (total),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int mon_words = 0;
    int frame_no = 0;
    int ready_mode = 0;
    int ready_pi = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the frame is a list of words built straight from the
    // snapshot values; checksum is the XOR of the list.
    task automatic push_frame(input logic [NB-1:0][63:0] c, input logic [63:0] t);
        logic [31:0] w[$];
        logic [31:0] ck;
        exp_t e;
        w.push_back(32'hA5A5_0020);
        w.push_back(t[31:0]);
        w.push_back(t[63:32]);
        for (int k = 0; k < NB; k++) begin
            w.push_back(c[k][31:0]);
            w.push_back(c[k][63:32]);
        end
        ck = '0;
        foreach (w[i]) ck ^= w[i];
        foreach (w[i]) begin
            e.data = w[i];
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        e.data = ck;
        e.last = 1'b1;
        exp_q.push_back(e);
        exp_done++;
        frame_no++;
        $display("frame %0d queued: %0d words, checksum 0x%08h", frame_no, w.size() + 1, ck);
    endtask

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ((ready_pi % 4) == 0) || ((ready_pi % 4) == 3);
                ready_pi++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: inputs are stable at the falling edge, so a valid&ready seen
    // here is the handshake of the next rising edge.
    logic [31:0] stall_data;
    logic        stall_last;
    bit          stall_pend = 1'b0;
    bit          last_hs = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            stall_pend = 1'b0;
            last_hs    = 1'b0;
            mon_words  = 0;
        end else begin
            if (done || last_hs)
                check(done == last_hs, "done_after_last", 32'(done), 32'(last_hs));
            if (last_hs)
                check(!out_valid && !busy && !out_last, "idle_after_last",
                      32'({out_valid, busy, out_last}), 32'd0);
            if (done) done_cnt++;
            if (stall_pend)
                check(out_data == stall_data && out_last == stall_last, "stall_hold",
                      out_data, stall_data);
            if (out_valid)
                check(busy == 1'b1, "busy_while_valid", 32'(busy), 32'd1);
            last_hs = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", out_data, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(out_data == mon_e.data && out_last == mon_e.last,
                          $sformatf("word%0d", mon_words), {out_data[30:0], out_last},
                          {mon_e.data[30:0], mon_e.last});
                end
                if (out_last) begin
                    $display("frame done at word %0d, last=0x%08h", mon_words, out_data);
                    mon_words = 0;
                    last_hs   = 1'b1;
                end else begin
                    mon_words++;
                end
            end
            stall_pend = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end
    end

    // Called at posedge+1; start is sampled at the following rising edge.
    task automatic issue_start();
        push_frame(counts, total);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check(out_valid && busy, "valid_after_start", 32'({out_valid, busy}), 32'd3);
        check(out_data == 32'hA5A5_0020, "header_first", out_data, 32'hA5A5_0020);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(done, "done_timeout", 32'(done), 32'd1);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < NB; k++) counts[k] = {$urandom, $urandom};
        total = {$urandom, $urandom};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dsave;
        int n;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check(!out_valid && !out_last && !busy && !done, "reset_ctrl",
              32'({out_valid, out_last, busy, done}), 32'd0);
        check(out_data == 32'd0, "reset_data", out_data, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // All-zero snapshot.
        issue_start();
        wait_done(300);
        check(exp_q.size() == 0, "queue_empty_t1", 32'(exp_q.size()), 32'd0);

        // Bin k = k, total = 400.
        for (int k = 0; k < NB; k++) counts[k] = 64'(k);
        total = 64'd400;
        @(posedge clk);
        #1;
        issue_start();
        wait_done(300);

        // Same data with stalling consumer.
        ready_mode = 1;
        ready_pi = 0;
        @(posedge clk);
        #1;
        issue_start();
        wait_done(600);
        check(exp_q.size() == 0, "queue_empty_t3", 32'(exp_q.size()), 32'd0);

        // Inputs change after snapshot; start mid-frame is ignored.
        ready_mode = 0;
        randomize_data();
        @(posedge clk);
        #1;
        issue_start();
        counts = '1;
        total  = '1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check(!out_valid && !busy, "no_queued_start", 32'({out_valid, busy}), 32'd0);
        end

        // Reset in the middle of a frame.
        randomize_data();
        issue_start();
        n = 0;
        while (mon_words < 20 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        rst = 1'b0;
        #1;
        check(!out_valid && !out_last && !busy && !done, "async_reset_ctrl",
              32'({out_valid, out_last, busy, done}), 32'd0);
        check(out_data == 32'd0, "async_reset_data", out_data, 32'd0);
        exp_q.delete();
        exp_done--;
        dsave = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(done_cnt == dsave, "no_done_on_reset", 32'(done_cnt), 32'(dsave));
        check(!out_valid, "idle_after_reset", 32'(out_valid), 32'd0);
        ready_mode = 2;
        randomize_data();
        issue_start();
        wait_done(1000);

        // Back-to-back frames: second start issued in the done cycle.
        ready_mode = 0;
        @(posedge clk);
        #1;
        randomize_data();
        issue_start();
        wait_done(300);
        randomize_data();
        issue_start();
        wait_done(300);

        // A few random frames with random backpressure.
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            @(posedge clk);
            #1;
            randomize_data();
            issue_start();
            wait_done(1000);
        end

        repeat (3) @(posedge clk);
        #1;
        check(done_cnt == exp_done, "done_count", 32'(done_cnt), 32'(exp_done));
        check(exp_q.size() == 0, "queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/part_readout.md
# part_readout

Downstream of the partition (poker) test counter stage. On a `start` pulse it snapshots the 32 × 64-bit bin counters and the 64-bit sample total, then streams them out as a framed sequence of 32-bit words over a valid/ready interface, ending with an XOR checksum word. The host-side link consumes the stream. The counter stage may keep counting or be cleared while the frame drains, because the frame is built only from the snapshot.

## Interface
Parameters:
- `NUM_BINS`, default 32: number of 64-bit counters captured.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: snapshot-and-send request, sampled in IDLE only.
- `counts`  in  64 × [NUM_BINS-1:0]: live bin counters from the partition stage.
- `total`  in  64: live sample total from the partition stage.
- `out_data`  out  32: frame word.
- `out_valid`  out  1: `out_data` is valid.
- `out_last`  out  1: current word is the final (checksum) word.
- `out_ready`  in  1: consumer accepts the word.
- `busy`  out  1: high from snapshot until the final handshake.
- `done`  out  1: one-cycle pulse after the final handshake.

## Operation
- Frame length `FRAME_LEN` = 2·NUM_BINS + 4 words (68 at default). Word index `idx` runs from 0 to FRAME_LEN-1:
  - idx 0: header = 32'hA5A5_0000 | NUM_BINS[15:0].
  - idx 1: total[31:0].
  - idx 2: total[63:32].
  - idx 3+2k: bin k [31:0].
  - idx 4+2k: bin k [63:32], for k = 0..NUM_BINS-1.
  - idx FRAME_LEN-1: checksum, the XOR of all preceding frame words.
- States:
  - IDLE: `start`=1 latches `counts`/`total` into snapshot registers, clears `idx` and `cksum`, then goes to SEND.
  - SEND: on each handshake (`out_valid & out_ready`), XOR `out_data` into `cksum` and increment `idx`. A handshake at idx FRAME_LEN-1 goes to IDLE and sets `done` for the next cycle.
- `start` while in SEND is ignored; it is neither queued nor restarts the frame.
- Checksum word is sourced from the `cksum` register, which by then holds the XOR of words 0..FRAME_LEN-2.
- `idx` width is $clog2(FRAME_LEN). The counter does not wrap within a frame.
- Reset values:
  - State is IDLE.
  - `out_valid`, `out_last`, `busy`, `done`, `idx`, `cksum` and `out_data` are all 0.
  - Snapshot registers are 0.

## Timing
- `start` high at edge N (in IDLE): snapshot taken at edge N, and `out_valid`/`busy` are high in cycle N+1 with the header on `out_data`.
- `out_valid` is registered and stays high throughout SEND. While `out_ready`=0, `out_data` and `out_last` hold stable.
- With `out_ready` held at 1: one word per cycle, and the full frame takes FRAME_LEN cycles.
- `out_last` is high only while idx = FRAME_LEN-1.
- Final handshake at edge M:
  - `out_valid`, `out_last` and `busy` are low in cycle M+1.
  - `done` is high in cycle M+1 only.
- A new `start` sampled at edge M+1 is accepted, giving back-to-back frames with a 1-cycle gap.
- Reset asserted mid-frame immediately forces IDLE with all outputs low. The partial frame is abandoned, and no `done` pulse is generated.
- Changes on `counts`/`total` after the snapshot edge never affect the frame in flight.

## Structure
- Shared package `part_pkg`:
  - `NUM_BINS_DEFAULT` = 32.
  - `HDR_MAGIC` = 16'hA5A5.
  - State enum `readout_state_t` {IDLE, SEND}.
  - Function `frame_len(n)` = 2n+4.
- Single module, no sub-modules. The word mux (index → snapshot slice) is a combinational block feeding a registered `out_data`.

## Test plan
- Reset, all snapshots zero, NUM_BINS=32, `start` pulse, `out_ready`=1:
  - 68 words.
  - Header 0xA5A50020, then 66 zeros.
  - Checksum 0xA5A50020 with `out_last`=1.
  - `done` pulses once.
- Bin k = k, total = 400, `out_ready`=1:
  - Word 1 = 0x190, word 3+2k = k, and all high halves 0.
  - Checksum 0xA5A501B0.
- Same data with `out_ready` toggled 1,0,0,1 repeatedly: identical 68-word sequence, with `out_data` stable during every stall.
- Change `counts`/`total` to all-ones one cycle after `start`: streamed frame still equals the snapshot; assert `start` again mid-frame and check it is ignored.
- Assert `rst` low at word 20:
  - Outputs go low asynchronously and no `done` pulse appears.
  - After release, a fresh `start` produces a complete, correct frame.
- Two `start` pulses, the second one cycle after `done`: two complete frames, each with the correct checksum.
